top2_frame_accum: RTL

TOP2_FRAME_ACCUM -- requirements
Module: top2_frame_accum

---
 rtl/top2_frame_accum_if.sv | 56 +++++
 rtl/top2_frame_accum.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/top2_frame_accum_if.sv
// Bundle for the frame top-2 accumulator: sample stream in, the lane bus to and from
// the external 4-input top-2 compare stage, and the frame result stream out.
interface top2_frame_accum_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              in_last;

  logic signed [7:0] cmp_data_0;
  logic signed [7:0] cmp_data_1;
  logic signed [7:0] cmp_data_2;
  logic signed [7:0] cmp_data_3;
  logic [7:0]        cmp_ID_0;
  logic [7:0]        cmp_ID_1;
  logic [7:0]        cmp_ID_2;
  logic [7:0]        cmp_ID_3;
  logic signed [7:0] cmp_max_data_0;
  logic signed [7:0] cmp_max_data_1;
  logic [7:0]        cmp_max_ID_0;
  logic [7:0]        cmp_max_ID_1;

  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_max_data_0;
  logic signed [7:0] out_max_data_1;
  logic [7:0]        out_max_ID_0;
  logic [7:0]        out_max_ID_1;
  logic [7:0]        out_count;
  logic              out_trunc;

  // Both streams are valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; valid and its payload hold steady until that transfer.
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output cmp_data_0, cmp_data_1, cmp_data_2, cmp_data_3,
    output cmp_ID_0, cmp_ID_1, cmp_ID_2, cmp_ID_3,
    input  cmp_max_data_0, cmp_max_data_1, cmp_max_ID_0, cmp_max_ID_1,
    output out_valid,
    input  out_ready,
    output out_max_data_0, out_max_data_1, out_max_ID_0, out_max_ID_1,
    output out_count, out_trunc
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  cmp_data_0, cmp_data_1, cmp_data_2, cmp_data_3,
    input  cmp_ID_0, cmp_ID_1, cmp_ID_2, cmp_ID_3,
    output cmp_max_data_0, cmp_max_data_1, cmp_max_ID_0, cmp_max_ID_1,
    input  out_valid,
    output out_ready,
    input  out_max_data_0, out_max_data_1, out_max_ID_0, out_max_ID_1,
    input  out_count, out_trunc
  );
endinterface

// File: rtl/top2_frame_accum.sv
// Frame top-2 accumulator: gathers samples four at a time into compare lanes, merges each
// group's top-2 (from the external compare stage) into a running pair, emits one result per frame.
module top2_frame_accum (
    input  logic                clk,
    input  logic                rst,
    top2_frame_accum_if.slave   bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {COLLECT = 2'd0, CMP = 2'd1, OUT = 2'd2} state_t;

    localparam logic signed [7:0] PAD_DATA = 8'sh80;
    localparam logic [7:0]        PAD_ID   = 8'hFF;

    state_t            state;
    logic [7:0]        count;
    logic signed [7:0] lane_data [4];
    logic [7:0]        lane_id [4];
    logic signed [7:0] r0, r1;
    logic [7:0]        id0, id1;
    logic              frame_end;
    logic              trunc_pend;
    logic              in_ready_q;
    logic              out_valid_q;
    logic signed [7:0] out_d0, out_d1;
    logic [7:0]        out_i0, out_i1;
    logic [7:0]        out_cnt;
    logic              out_trc;

    logic [1:0]        lane;
    logic              accept;
    logic              limit_hit;
    logic              end_now;
    logic signed [7:0] new_r0, new_r1;
    logic [7:0]        new_id0, new_id1;

    assign lane      = count[1:0];
    assign accept    = bus.in_valid && in_ready_q;
    assign limit_hit = (count == 8'd254);
    assign end_now   = bus.in_last || limit_hit;

    // Strictly larger wins; an equal value wins only against a padding entry, so a real
    // -128 sample displaces the (-128, FF) padding entry the running pair starts from.
    function automatic logic beats(input logic signed [7:0] a, input logic [7:0] aid,
                                   input logic signed [7:0] b, input logic [7:0] bid);
        return (a > b) || ((a == b) && (bid == PAD_ID) && (aid != PAD_ID));
    endfunction

    always_comb begin
        new_r0  = r0;
        new_id0 = id0;
        new_r1  = r1;
        new_id1 = id1;
        if (beats(bus.cmp_max_data_0, bus.cmp_max_ID_0, r0, id0)) begin
            new_r0  = bus.cmp_max_data_0;
            new_id0 = bus.cmp_max_ID_0;
            if (beats(bus.cmp_max_data_1, bus.cmp_max_ID_1, r0, id0)) begin
                new_r1  = bus.cmp_max_data_1;
                new_id1 = bus.cmp_max_ID_1;
            end else begin
                new_r1  = r0;
                new_id1 = id0;
            end
        end else if (beats(bus.cmp_max_data_0, bus.cmp_max_ID_0, r1, id1)) begin
            new_r1  = bus.cmp_max_data_0;
            new_id1 = bus.cmp_max_ID_0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            count       <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                lane_data[i] <= PAD_DATA;
                lane_id[i]   <= PAD_ID;
            end
            r0          <= PAD_DATA;
            r1          <= PAD_DATA;
            id0         <= PAD_ID;
            id1         <= PAD_ID;
            frame_end   <= 1'b0;
            trunc_pend  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_d0      <= 8'sd0;
            out_d1      <= 8'sd0;
            out_i0      <= 8'd0;
            out_i1      <= 8'd0;
            out_cnt     <= 8'd0;
            out_trc     <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        lane_data[lane] <= bus.in_data;
                        lane_id[lane]   <= count;
                        count           <= count + 8'd1;
                        if (lane == 2'd3 || end_now) begin
                            state      <= CMP;
                            in_ready_q <= 1'b0;
                            frame_end  <= end_now;
                            trunc_pend <= limit_hit && !bus.in_last;
                        end
                    end
                end
                CMP: begin
                    r0  <= new_r0;
                    r1  <= new_r1;
                    id0 <= new_id0;
                    id1 <= new_id1;
                    if (frame_end) begin
                        state       <= OUT;
                        out_valid_q <= 1'b1;
                        out_d0      <= new_r0;
                        out_d1      <= new_r1;
                        out_i0      <= new_id0;
                        out_i1      <= new_id1;
                        out_cnt     <= count;
                        out_trc     <= trunc_pend;
                    end else begin
                        state      <= COLLECT;
                        in_ready_q <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            lane_data[i] <= PAD_DATA;
                            lane_id[i]   <= PAD_ID;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state       <= COLLECT;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        count       <= 8'd0;
                        r0          <= PAD_DATA;
                        r1          <= PAD_DATA;
                        id0         <= PAD_ID;
                        id1         <= PAD_ID;
                        for (int i = 0; i < 4; i++) begin
                            lane_data[i] <= PAD_DATA;
                            lane_id[i]   <= PAD_ID;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.cmp_data_0     = lane_data[0];
    assign bus.cmp_data_1     = lane_data[1];
    assign bus.cmp_data_2     = lane_data[2];
    assign bus.cmp_data_3     = lane_data[3];
    assign bus.cmp_ID_0       = lane_id[0];
    assign bus.cmp_ID_1       = lane_id[1];
    assign bus.cmp_ID_2       = lane_id[2];
    assign bus.cmp_ID_3       = lane_id[3];
    assign bus.out_max_data_0 = out_d0;
    assign bus.out_max_data_1 = out_d1;
    assign bus.out_max_ID_0   = out_i0;
    assign bus.out_max_ID_1   = out_i1;
    assign bus.out_count      = out_cnt;
    assign bus.out_trunc      = out_trc;
    assign dbg_state          = state;
endmodule
